cmsdk_ahb_matrix_decoder_param: RTL and testbench

Parametrised input-port address decoder for the CMSDK AHB bus matrix. It is the generalised successor of the fixed two-port per-slave decoders. Each instance sits between one matrix input stage and NUM_PORTS output stages. It decodes the address phase to a one-hot output select, with optional boot remap of region 0. It then multiplexes the data-phase response from the selected port. An integrated two-cycle ERROR default slave and a saturating unmapped-access counter are built in.

---
 rtl/cmsdk_ahb_matrix_pkg.sv | 23 ++
 rtl/cmsdk_ahb_matrix_dft_slv_err.sv | 56 +++++
 rtl/cmsdk_ahb_matrix_decoder_param.sv | 126 ++++++++++++
 tb/tb_cmsdk_ahb_matrix_decoder_param.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmsdk_ahb_matrix_pkg.sv
// Shared constants and types for the CMSDK AHB bus matrix input-port decoders.
package cmsdk_ahb_matrix_pkg;

  localparam logic [1:0] TRN_IDLE   = 2'b00;
  localparam logic [1:0] TRN_BUSY   = 2'b01;
  localparam logic [1:0] TRN_NONSEQ = 2'b10;
  localparam logic [1:0] TRN_SEQ    = 2'b11;

  localparam logic [1:0] RSP_OKAY  = 2'b00;
  localparam logic [1:0] RSP_ERROR = 2'b01;

  typedef logic [1:0] dft_state_t;

  localparam dft_state_t DFT_IDLE = 2'd0;
  localparam dft_state_t DFT_ERR1 = 2'd1;
  localparam dft_state_t DFT_ERR2 = 2'd2;

  // NONSEQ and SEQ both carry a real transfer; IDLE and BUSY do not.
  function automatic logic is_xfer(input logic [1:0] trans);
    return trans[1];
  endfunction

endpackage

// File: rtl/cmsdk_ahb_matrix_dft_slv_err.sv
// Default slave for unmapped addresses: two-cycle ERROR response state machine
// plus a saturating count of the transfers it has rejected.
module cmsdk_ahb_matrix_dft_slv_err
  import cmsdk_ahb_matrix_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             xfer_req,
  input  logic             err_cnt_clr,
  output dft_state_t       state,
  output logic [CNT_W-1:0] err_cnt
);

  dft_state_t       state_q, state_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_start;

  // ERR1 ignores new requests: it is the stall cycle, so the input stage
  // cannot be presenting an accepted transfer while it is active.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DFT_IDLE: if (xfer_req) state_d = DFT_ERR1;
      DFT_ERR1: state_d = DFT_ERR2;
      DFT_ERR2: state_d = xfer_req ? DFT_ERR1 : DFT_IDLE;
      default:  state_d = DFT_IDLE;
    endcase
  end

  assign err_start = (state_d == DFT_ERR1) && (state_q != DFT_ERR1);

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_cnt_clr) begin
      err_cnt_d = '0;
    end else if (err_start && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= DFT_IDLE;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign state   = state_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: rtl/cmsdk_ahb_matrix_decoder_param.sv
// Input-port address decoder for the AHB bus matrix: address-phase one-hot
// select with optional region-0 remap, data-phase response mux, default slave.
module cmsdk_ahb_matrix_decoder_param
  import cmsdk_ahb_matrix_pkg::*;
#(
  parameter int                                NUM_PORTS    = 2,
  parameter int                                ADDR_LO      = 10,
  parameter int                                UW           = 32,
  parameter logic [NUM_PORTS*(32-ADDR_LO)-1:0] REGION_BASE  = '0,
  parameter logic [NUM_PORTS*(32-ADDR_LO)-1:0] REGION_LIMIT = '0,
  parameter logic [31-ADDR_LO:0]               REMAP_BASE   = '0,
  parameter int                                CNT_W        = 8
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    HREADYS,
  input  logic                    sel_dec,
  input  logic [31-ADDR_LO:0]     decode_addr_dec,
  input  logic [1:0]              trans_dec,
  input  logic                    remap_dec,
  input  logic [NUM_PORTS-1:0]    active_vec,
  input  logic [NUM_PORTS-1:0]    readyout_vec,
  input  logic [2*NUM_PORTS-1:0]  resp_vec,
  input  logic [32*NUM_PORTS-1:0] rdata_vec,
  input  logic [UW*NUM_PORTS-1:0] ruser_vec,
  input  logic                    err_cnt_clr,
  output logic [NUM_PORTS-1:0]    sel_vec,
  output logic                    active_dec,
  output logic                    HREADYOUTS,
  output logic [1:0]              HRESPS,
  output logic [31:0]             HRDATAS,
  output logic [UW-1:0]           HRUSERS,
  output logic [CNT_W-1:0]        err_cnt
);

  localparam int AW = 32 - ADDR_LO;
  localparam int PW = $clog2(NUM_PORTS + 1);
  localparam logic [PW-1:0] DFT_IDX = PW'(NUM_PORTS);

  logic [AW-1:0]        base_v  [NUM_PORTS];
  logic [AW-1:0]        limit_v [NUM_PORTS];
  logic [NUM_PORTS-1:0] hit_vec;
  logic [PW-1:0]        decoded_port;
  logic [PW-1:0]        addr_port;
  logic [PW-1:0]        data_port_q, data_port_d;
  logic                 xfer_req;
  dft_state_t           dft_state;

  // Remap moves region 0 to REMAP_BASE while keeping its size.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      base_v[i]  = REGION_BASE[i*AW +: AW];
      limit_v[i] = REGION_LIMIT[i*AW +: AW];
    end
    if (remap_dec) begin
      base_v[0]  = REMAP_BASE;
      limit_v[0] = REMAP_BASE + (REGION_LIMIT[AW-1:0] - REGION_BASE[AW-1:0]);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      hit_vec[i] = (decode_addr_dec >= base_v[i]) && (decode_addr_dec <= limit_v[i]);
    end
  end

  always_comb begin
    decoded_port = DFT_IDX;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (hit_vec[i]) decoded_port = PW'(i);
    end
  end

  // An IDLE address phase keeps pointing at the current data-phase port so
  // output stages are not reselected across IDLE gaps.
  assign addr_port = (trans_dec == TRN_IDLE) ? data_port_q : decoded_port;

  always_comb begin
    active_dec = 1'b1;
    for (int i = 0; i < NUM_PORTS; i++) begin
      sel_vec[i] = sel_dec && (addr_port == PW'(i));
      if (addr_port == PW'(i)) active_dec = active_vec[i];
    end
  end

  // Handshake: an address phase is accepted on the HCLK edge where HREADYS=1;
  // the data phase then completes on the first edge where HREADYOUTS=1.
  assign data_port_d = HREADYS ? addr_port : data_port_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      data_port_q <= '0;
    end else begin
      data_port_q <= data_port_d;
    end
  end

  assign xfer_req = (addr_port == DFT_IDX) && sel_dec && is_xfer(trans_dec) && HREADYS;

  cmsdk_ahb_matrix_dft_slv_err #(
    .CNT_W (CNT_W)
  ) u_dft_slv_err (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .xfer_req    (xfer_req),
    .err_cnt_clr (err_cnt_clr),
    .state       (dft_state),
    .err_cnt     (err_cnt)
  );

  always_comb begin
    HREADYOUTS = (dft_state != DFT_ERR1);
    HRESPS     = (dft_state == DFT_IDLE) ? RSP_OKAY : RSP_ERROR;
    HRDATAS    = '0;
    HRUSERS    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (data_port_q == PW'(i)) begin
        HREADYOUTS = readyout_vec[i];
        HRESPS     = resp_vec[2*i +: 2];
        HRDATAS    = rdata_vec[32*i +: 32];
        HRUSERS    = ruser_vec[UW*i +: UW];
      end
    end
  end

endmodule

// File: tb/tb_cmsdk_ahb_matrix_decoder_param.sv
// Bench for cmsdk_ahb_matrix_decoder_param: directed scenarios plus random
// traffic checked against an address-range reference model.
module tb_cmsdk_ahb_matrix_decoder_param;
  import cmsdk_ahb_matrix_pkg::*;

  localparam int NP = 3;
  localparam int AL = 10;
  localparam int AW = 32 - AL;
  localparam int UW = 16;
  localparam int CW = 8;
  localparam logic [NP*AW-1:0] RB     = {22'h080, 22'h040, 22'h000};
  localparam logic [NP*AW-1:0] RL     = {22'h0BF, 22'h07F, 22'h03F};
  localparam logic [NP*AW-1:0] RL_OVL = {22'h0BF, 22'h07F, 22'h05F};
  localparam logic [AW-1:0]    RMB    = 22'h080;

  // ---------------- clock / reset ----------------
  logic HCLK = 1'b0;
  logic HRESETn;
  always #5 HCLK = ~HCLK;

  logic              HREADYS, sel_dec, remap_dec, err_cnt_clr;
  logic [AW-1:0]     decode_addr_dec;
  logic [1:0]        trans_dec;
  logic [NP-1:0]     active_vec, readyout_vec;
  logic [2*NP-1:0]   resp_vec;
  logic [32*NP-1:0]  rdata_vec;
  logic [UW*NP-1:0]  ruser_vec;
  logic [NP-1:0]     sel_vec, sel_vec_o;
  logic              active_dec, active_dec_o;
  logic              HREADYOUTS, HREADYOUTS_o;
  logic [1:0]        HRESPS, HRESPS_o;
  logic [31:0]       HRDATAS, HRDATAS_o;
  logic [UW-1:0]     HRUSERS, HRUSERS_o;
  logic [CW-1:0]     err_cnt, err_cnt_o;

  cmsdk_ahb_matrix_decoder_param #(
    .NUM_PORTS(NP), .ADDR_LO(AL), .UW(UW), .REGION_BASE(RB), .REGION_LIMIT(RL),
    .REMAP_BASE(RMB), .CNT_W(CW)
  ) u_dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HREADYS(HREADYS), .sel_dec(sel_dec),
    .decode_addr_dec(decode_addr_dec), .trans_dec(trans_dec), .remap_dec(remap_dec),
    .active_vec(active_vec), .readyout_vec(readyout_vec), .resp_vec(resp_vec),
    .rdata_vec(rdata_vec), .ruser_vec(ruser_vec), .err_cnt_clr(err_cnt_clr),
    .sel_vec(sel_vec), .active_dec(active_dec), .HREADYOUTS(HREADYOUTS),
    .HRESPS(HRESPS), .HRDATAS(HRDATAS), .HRUSERS(HRUSERS), .err_cnt(err_cnt)
  );

  // Second instance with region 0 widened so that it overlaps region 1.
  cmsdk_ahb_matrix_decoder_param #(
    .NUM_PORTS(NP), .ADDR_LO(AL), .UW(UW), .REGION_BASE(RB), .REGION_LIMIT(RL_OVL),
    .REMAP_BASE(RMB), .CNT_W(CW)
  ) u_dut_ovl (
    .HCLK(HCLK), .HRESETn(HRESETn), .HREADYS(HREADYS), .sel_dec(sel_dec),
    .decode_addr_dec(decode_addr_dec), .trans_dec(trans_dec), .remap_dec(remap_dec),
    .active_vec(active_vec), .readyout_vec(readyout_vec), .resp_vec(resp_vec),
    .rdata_vec(rdata_vec), .ruser_vec(ruser_vec), .err_cnt_clr(err_cnt_clr),
    .sel_vec(sel_vec_o), .active_dec(active_dec_o), .HREADYOUTS(HREADYOUTS_o),
    .HRESPS(HRESPS_o), .HRDATAS(HRDATAS_o), .HRUSERS(HRUSERS_o), .err_cnt(err_cnt_o)
  );

  // ---------------- reference model ----------------
  int unsigned m_lo [NP] = '{32'h0000_0000, 32'h0001_0000, 32'h0002_0000};
  int unsigned m_hi [NP] = '{32'h0000_FFFF, 32'h0001_FFFF, 32'h0002_FFFF};
  localparam int unsigned REMAP_BYTE  = 32'h0002_0000;
  localparam int unsigned OVL_HI0     = 32'h0001_7FFF;

  int m_dp, m_dp_o, m_st, m_cnt;        // m_st: 0 idle, 1 error wait, 2 error done
  int nx_dp, nx_dp_o, nx_st, nx_cnt;

  int n_vec = 0;
  int n_bad = 0;
  logic [2:0] exp_q[$];

  function automatic int m_decode(input logic [AW-1:0] blk, input bit rmp, input bit ovl);
    int unsigned addr;
    int unsigned lo, hi;
    addr = {blk, 10'b0};
    for (int p = 0; p < NP; p++) begin
      lo = m_lo[p];
      hi = m_hi[p];
      if (p == 0 && ovl) hi = OVL_HI0;
      if (p == 0 && rmp) begin
        hi = REMAP_BYTE + (hi - lo);
        lo = REMAP_BYTE;
      end
      if (addr >= lo && addr <= hi) return p;
    end
    return NP;
  endfunction

  task automatic model_reset();
    m_dp = 0; m_dp_o = 0; m_st = 0; m_cnt = 0;
  endtask

  // ---------------- scoreboard check ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic rand_ports();
    active_vec   = NP'($urandom);
    readyout_vec = NP'($urandom);
    resp_vec     = 6'($urandom);
    rdata_vec    = {$urandom, $urandom, $urandom};
    ruser_vec    = 48'({$urandom, $urandom});
  endtask

  // hr_mode: 0 -> HREADYS=0, 1 -> HREADYS=1, 2 -> follow expected HREADYOUTS, 3 -> random
  task automatic drive(input bit sel, input logic [AW-1:0] blk, input logic [1:0] trn,
                       input bit rmp, input bit clr, input int hr_mode, input bit rnd);
    logic        e_rdy, hr, qual;
    logic [1:0]  e_rsp;
    logic [31:0] e_rd, e_sel;
    logic [UW-1:0] e_ru;
    logic        e_act;
    int          ap, ap_o;
    @(negedge HCLK);
    if (rnd) rand_ports();
    if (m_dp < NP) begin
      e_rdy = readyout_vec[m_dp];
      e_rsp = resp_vec[2*m_dp +: 2];
      e_rd  = rdata_vec[32*m_dp +: 32];
      e_ru  = ruser_vec[UW*m_dp +: UW];
    end else begin
      e_rdy = (m_st != 1);
      e_rsp = (m_st == 0) ? 2'b00 : 2'b01;
      e_rd  = '0;
      e_ru  = '0;
    end
    case (hr_mode)
      0:       hr = 1'b0;
      1:       hr = 1'b1;
      2:       hr = e_rdy;
      default: hr = ($urandom_range(0, 3) != 0);
    endcase
    HREADYS = hr; sel_dec = sel; decode_addr_dec = blk; trans_dec = trn;
    remap_dec = rmp; err_cnt_clr = clr;
    ap    = (trn == 2'b00) ? m_dp   : m_decode(blk, rmp, 1'b0);
    ap_o  = (trn == 2'b00) ? m_dp_o : m_decode(blk, rmp, 1'b1);
    e_sel = (sel && ap < NP) ? (32'd1 << ap) : 32'd0;
    e_act = (ap < NP) ? active_vec[ap] : 1'b1;
    #1;
    chk("sel_vec", 32'(sel_vec), e_sel);
    chk("sel_vec_ovl", 32'(sel_vec_o), (sel && ap_o < NP) ? (32'd1 << ap_o) : 32'd0);
    chk("active_dec", 32'(active_dec), 32'(e_act));
    chk("hreadyouts", 32'(HREADYOUTS), 32'(e_rdy));
    chk("hresps", 32'(HRESPS), 32'(e_rsp));
    chk("hrdatas", HRDATAS, e_rd);
    chk("hrusers", 32'(HRUSERS), 32'(e_ru));
    chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
    qual = (ap == NP) && sel && trn[1] && hr;
    if (m_st == 1) nx_st = 2;
    else           nx_st = qual ? 1 : 0;
    if (clr)                                  nx_cnt = 0;
    else if (nx_st == 1 && m_st != 1 && m_cnt < 255) nx_cnt = m_cnt + 1;
    else                                      nx_cnt = m_cnt;
    nx_dp   = hr ? ap   : m_dp;
    nx_dp_o = hr ? ap_o : m_dp_o;
  endtask

  task automatic tick();
    @(posedge HCLK);
    m_dp = nx_dp; m_dp_o = nx_dp_o; m_st = nx_st; m_cnt = nx_cnt;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    HRESETn = 1'b0;
    HREADYS = 1'b1; sel_dec = 1'b0; decode_addr_dec = '0; trans_dec = TRN_IDLE;
    remap_dec = 1'b0; err_cnt_clr = 1'b0;
    rand_ports();
    model_reset();
    repeat (3) @(posedge HCLK);
    drive(1'b0, '0, TRN_IDLE, 1'b0, 1'b0, 1, 1'b1);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_hreadyouts", 32'(HREADYOUTS), 32'(readyout_vec[0]));
    chk("rst_hresps", 32'(HRESPS), 32'(resp_vec[1:0]));
    HRESETn = 1'b1;
    tick();

    // mapped NONSEQ to 0x18000, then its data phase
    drive(1'b1, 22'h060, TRN_NONSEQ, 1'b0, 1'b0, 1, 1'b1);
    chk("dec_0x18000", 32'(sel_vec), 32'b010);
    tick();
    rand_ports();
    rdata_vec[63:32] = 32'hA5A5_0001;
    drive(1'b1, 22'h060, TRN_IDLE, 1'b0, 1'b0, 1, 1'b0);
    chk("rdata_port1", HRDATAS, 32'hA5A5_0001);
    tick();

    // IDLE with a region-0 address keeps port 1
    drive(1'b1, 22'h010, TRN_IDLE, 1'b0, 1'b0, 1, 1'b1);
    chk("idle_hold", 32'(sel_vec), 32'b010);
    tick();

    // remap of region 0 onto region 2
    drive(1'b1, 22'h080, TRN_NONSEQ, 1'b1, 1'b0, 1, 1'b1);
    chk("remap_on", 32'(sel_vec), 32'b001);
    tick();
    drive(1'b1, 22'h080, TRN_NONSEQ, 1'b0, 1'b0, 1, 1'b1);
    chk("remap_off", 32'(sel_vec), 32'b100);
    tick();

    // overlapping regions 0 and 1: lowest index wins
    drive(1'b1, 22'h050, TRN_NONSEQ, 1'b0, 1'b0, 1, 1'b1);
    chk("overlap_sel", 32'(sel_vec_o), 32'b001);
    tick();

    // unmapped access: two-cycle ERROR
    drive(1'b1, 22'h100, TRN_NONSEQ, 1'b0, 1'b0, 1, 1'b1);
    chk("unmapped_sel", 32'(sel_vec), 32'd0);
    tick();
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b101);
    repeat (2) begin
      drive(1'b0, '0, TRN_IDLE, 1'b0, 1'b0, 2, 1'b1);
      chk("err_resp", 32'({HREADYOUTS, HRESPS}), 32'(exp_q.pop_front()));
      chk("err_cnt_one", 32'(err_cnt), 32'd1);
      tick();
    end

    // back-to-back unmapped transfers
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b101);
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b101);
    repeat (5) begin
      drive(1'b1, 22'h100, TRN_NONSEQ, 1'b0, 1'b0, 2, 1'b1);
      chk("b2b_resp", 32'({HREADYOUTS, HRESPS}), 32'(exp_q.pop_front()));
      tick();
    end

    // asynchronous reset in the middle of ERR1
    #2;
    HRESETn = 1'b0;
    model_reset();
    #1;
    chk("rst_mid_rdy", 32'(HREADYOUTS), 32'(readyout_vec[0]));
    chk("rst_mid_cnt", 32'(err_cnt), 32'd0);
    #1;
    HRESETn = 1'b1;
    drive(1'b0, '0, TRN_IDLE, 1'b0, 1'b0, 1, 1'b1);
    chk("post_rst_rdy", 32'(HREADYOUTS), 32'(readyout_vec[0]));
    tick();

    // saturation of the unmapped counter
    repeat (700) begin
      drive(1'b1, 22'h100, TRN_NONSEQ, 1'b0, 1'b0, 2, 1'b1);
      tick();
    end
    drive(1'b0, '0, TRN_IDLE, 1'b0, 1'b0, 2, 1'b1);
    chk("err_cnt_sat", 32'(err_cnt), 32'd255);
    tick();
    repeat (3) begin
      drive(1'b0, '0, TRN_IDLE, 1'b0, 1'b0, 2, 1'b1);
      tick();
    end
    drive(1'b1, 22'h100, TRN_NONSEQ, 1'b0, 1'b1, 2, 1'b1);
    tick();
    drive(1'b0, '0, TRN_IDLE, 1'b0, 1'b0, 2, 1'b1);
    chk("clr_priority", 32'(err_cnt), 32'd0);
    tick();

    // random traffic
    repeat (400) begin
      logic [AW-1:0] blk;
      blk = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 32'h13F));
      drive($urandom_range(0, 7) != 0, blk, 2'($urandom_range(0, 3)),
            $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
            ($urandom_range(0, 4) == 0) ? 3 : 2, 1'b1);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // ---------------- final report on timeout ----------------
  initial begin
    #1_000_000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
